// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for the 5-stage pipeline: load-use stall, taken-branch flush and
// EX operand forwarding. State and counters update on the falling clock edge.
module pipe_hazard_ctrl #(
  parameter logic [15:0] CntMax = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic [4:0]  ex_rs,
  input  logic [4:0]  ex_rt,
  input  logic [4:0]  ex_rw,
  input  logic        ex_regwr,
  input  logic        ex_memtoreg,
  input  logic        ex_br_taken,
  input  logic [4:0]  mem_rw,
  input  logic        mem_regwr,
  input  logic [4:0]  wr_rw,
  input  logic        wr_regwr,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {StRun, StLuStall, StBrFlush} state_e;

  state_e      state_q, state_d;
  logic [15:0] stall_cnt_q, flush_cnt_q;
  logic        stall_inc, flush_inc;
  logic        lu;

  assign lu = ex_memtoreg & ex_regwr & (ex_rw != 5'd0) &
              ((ex_rw == id_rs) | (id_uses_rt & (ex_rw == id_rt)));

  always_comb begin
    state_d     = StRun;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          if (ex_br_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            flush_inc   = 1'b1;
            state_d     = StBrFlush;
          end else if (lu) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_inc   = 1'b1;
            state_d     = StLuStall;
          end
        end
        // The stalled load has moved on; only a branch resolving now matters.
        StLuStall: begin
          if (ex_br_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            flush_inc   = 1'b1;
            state_d     = StBrFlush;
          end
        end
        // ID holds a nop and EX a bubble, so neither hazard source is real.
        StBrFlush: state_d = StRun;
        default:   state_d = StRun;
      endcase
    end
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!rst) begin
      if (mem_regwr && mem_rw != 5'd0 && mem_rw == ex_rs) begin
        fwd_a = 2'b01;
      end else if (wr_regwr && wr_rw != 5'd0 && wr_rw == ex_rs) begin
        fwd_a = 2'b10;
      end
      if (mem_regwr && mem_rw != 5'd0 && mem_rw == ex_rt) begin
        fwd_b = 2'b01;
      end else if (wr_regwr && wr_rw != 5'd0 && wr_rw == ex_rt) begin
        fwd_b = 2'b10;
      end
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q <= state_d;
      if (stall_inc && stall_cnt_q != CntMax) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (flush_inc && flush_cnt_q != CntMax) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a combinational vector table in RUN plus
// hand-written multi-cycle sequences for stall, flush, reset and saturation.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_rw, mem_rw, wr_rw;
  logic        id_uses_rt, ex_regwr, ex_memtoreg, ex_br_taken, mem_regwr, wr_regwr;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;
  logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic [15:0] s_stall_cnt, s_flush_cnt;

  int n_vec = 0;
  int n_bad = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rw(ex_rw), .ex_regwr(ex_regwr),
    .ex_memtoreg(ex_memtoreg), .ex_br_taken(ex_br_taken), .mem_rw(mem_rw),
    .mem_regwr(mem_regwr), .wr_rw(wr_rw), .wr_regwr(wr_regwr), .pc_write(pc_write),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Same logic with a low ceiling so saturation is reachable in a short run.
  pipe_hazard_ctrl #(.CntMax(16'h00FF)) dut_sat (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rw(ex_rw), .ex_regwr(ex_regwr),
    .ex_memtoreg(ex_memtoreg), .ex_br_taken(ex_br_taken), .mem_rw(mem_rw),
    .mem_regwr(mem_regwr), .wr_rw(wr_rw), .wr_regwr(wr_regwr), .pc_write(s_pc_write),
    .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] id_rs, id_rt;
    logic       id_uses_rt;
    logic [4:0] ex_rs, ex_rt, ex_rw;
    logic       ex_regwr, ex_memtoreg, ex_br_taken;
    logic [4:0] mem_rw;
    logic       mem_regwr;
    logic [4:0] wr_rw;
    logic       wr_regwr;
    logic [5:0] exp_ctl;  // {pc_write, ifid_write, ifid_flush, idex_bubble, 2'b00}
    logic [1:0] exp_fa, exp_fb;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_ctl(input string name, input logic [3:0] exp);
    chk(name, {12'd0, pc_write, ifid_write, ifid_flush, idex_bubble}, {12'd0, exp});
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_rs = 0; ex_rt = 0; ex_rw = 0;
    ex_regwr = 0; ex_memtoreg = 0; ex_br_taken = 0; mem_rw = 0; mem_regwr = 0;
    wr_rw = 0; wr_regwr = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_lw(input logic [4:0] rw);
    ex_memtoreg = 1; ex_regwr = 1; ex_rw = rw;
  endtask

  task automatic chk_cnts(input string name);
    chk({name, ".stall_cnt"}, stall_cnt, exp_stall[15:0]);
    chk({name, ".flush_cnt"}, flush_cnt, exp_flush[15:0]);
  endtask

  localparam logic [3:0] Norm  = 4'b1100;
  localparam logic [3:0] Stall = 4'b0001;
  localparam logic [3:0] Flush = 4'b1111;
  localparam logic [3:0] Rst   = 4'b0011;

  initial begin
    //             name        rs rt urt exrs exrt exrw rw m2r br mrw mwr wrw wwr ctl        fa     fb
    vecs[0]  = '{"idle",       0, 0, 0,  0,   0,   0,   0, 0,  0, 0,  0,  0,  0, {Norm, 2'b0},  2'b00, 2'b00};
    vecs[1]  = '{"lu_rs",      8, 0, 0,  0,   0,   8,   1, 1,  0, 0,  0,  0,  0, {Stall, 2'b0}, 2'b00, 2'b00};
    vecs[2]  = '{"rt_gated",   0, 9, 0,  0,   0,   9,   1, 1,  0, 0,  0,  0,  0, {Norm, 2'b0},  2'b00, 2'b00};
    vecs[3]  = '{"rt_used",    0, 9, 1,  0,   0,   9,   1, 1,  0, 0,  0,  0,  0, {Stall, 2'b0}, 2'b00, 2'b00};
    vecs[4]  = '{"not_load",   8, 0, 0,  0,   0,   8,   1, 0,  0, 0,  0,  0,  0, {Norm, 2'b0},  2'b00, 2'b00};
    vecs[5]  = '{"lu_r0",      0, 0, 1,  0,   0,   0,   1, 1,  0, 0,  0,  0,  0, {Norm, 2'b0},  2'b00, 2'b00};
    vecs[6]  = '{"lw_nowr",    8, 0, 0,  0,   0,   8,   0, 1,  0, 0,  0,  0,  0, {Norm, 2'b0},  2'b00, 2'b00};
    vecs[7]  = '{"br",         0, 0, 0,  0,   0,   0,   0, 0,  1, 0,  0,  0,  0, {Flush, 2'b0}, 2'b00, 2'b00};
    vecs[8]  = '{"br_and_lu",  8, 0, 0,  0,   0,   8,   1, 1,  1, 0,  0,  0,  0, {Flush, 2'b0}, 2'b00, 2'b00};
    vecs[9]  = '{"fwd_mem",    0, 0, 0,  5,   0,   0,   0, 0,  0, 5,  1,  5,  1, {Norm, 2'b0},  2'b01, 2'b00};
    vecs[10] = '{"fwd_wr",     0, 0, 0,  5,   0,   0,   0, 0,  0, 5,  0,  5,  1, {Norm, 2'b0},  2'b10, 2'b00};
    vecs[11] = '{"fwd_r0",     0, 0, 0,  0,   0,   0,   0, 0,  0, 0,  1,  0,  1, {Norm, 2'b0},  2'b00, 2'b00};
    vecs[12] = '{"fwd_mix",    0, 0, 0,  3,   7,   0,   0, 0,  0, 3,  1,  7,  1, {Norm, 2'b0},  2'b01, 2'b10};
    vecs[13] = '{"fwd_both",   0, 0, 0,  7,   7,   0,   0, 0,  0, 7,  1,  7,  0, {Norm, 2'b0},  2'b01, 2'b01};
    vecs[14] = '{"fwd_none",   0, 0, 0,  4,   6,   0,   0, 0,  0, 2,  1,  6,  0, {Norm, 2'b0},  2'b00, 2'b00};

    // Reset: outputs forced even with hazards and forwarding matches present.
    rst = 1;
    idle();
    set_lw(8); id_rs = 8; ex_br_taken = 1; ex_rs = 5; mem_rw = 5; mem_regwr = 1;
    #1;
    chk_ctl("rst_ctl", Rst);
    chk("rst_fwd", {12'd0, fwd_a, fwd_b}, 16'd0);
    chk("rst_ctl_sat", {12'd0, s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble},
        {12'd0, Rst});
    chk("rst_fwd_sat", {12'd0, s_fwd_a, s_fwd_b}, 16'd0);
    tick();
    tick();
    chk_cnts("rst");
    chk("rst_stall_sat", s_stall_cnt, 16'd0);
    rst = 0;
    idle();
    #1;

    // Table: combinational outputs in RUN; inputs cleared before each edge.
    foreach (vecs[i]) begin
      id_rs = vecs[i].id_rs; id_rt = vecs[i].id_rt; id_uses_rt = vecs[i].id_uses_rt;
      ex_rs = vecs[i].ex_rs; ex_rt = vecs[i].ex_rt; ex_rw = vecs[i].ex_rw;
      ex_regwr = vecs[i].ex_regwr; ex_memtoreg = vecs[i].ex_memtoreg;
      ex_br_taken = vecs[i].ex_br_taken; mem_rw = vecs[i].mem_rw;
      mem_regwr = vecs[i].mem_regwr; wr_rw = vecs[i].wr_rw; wr_regwr = vecs[i].wr_regwr;
      #1;
      chk({vecs[i].name, ".ctl"}, {12'd0, pc_write, ifid_write, ifid_flush, idex_bubble},
          {12'd0, vecs[i].exp_ctl[5:2]});
      chk({vecs[i].name, ".fwd"}, {12'd0, fwd_a, fwd_b}, {12'd0, vecs[i].exp_fa, vecs[i].exp_fb});
      idle();
      tick();
    end
    chk_cnts("table");

    // Load-use on Rs: one stall cycle, lu ignored while stalled.
    set_lw(8); id_rs = 8;
    #1;
    chk_ctl("lu_stall", Stall);
    tick();
    exp_stall++;
    chk_ctl("lu_stall_next", Norm);
    chk_cnts("lu");
    idle();
    tick();
    chk_ctl("lu_back_run", Norm);

    // Rt load-use, then a taken branch honoured inside the stall cycle.
    set_lw(9); id_rt = 9; id_uses_rt = 1;
    #1;
    chk_ctl("rt_stall", Stall);
    tick();
    exp_stall++;
    ex_br_taken = 1;
    #1;
    chk_ctl("stall_br", Flush);
    tick();
    exp_flush++;
    chk_ctl("flush_ignores", Norm);
    chk_cnts("stall_br");
    idle();
    tick();

    // Branch with load-use in the same cycle: branch wins, no stall counted.
    set_lw(8); id_rs = 8; ex_br_taken = 1;
    #1;
    chk_ctl("br_lu", Flush);
    tick();
    exp_flush++;
    chk_ctl("br_lu_next", Norm);
    chk_cnts("br_lu");
    idle();
    tick();
    chk_ctl("br_lu_run", Norm);
    chk_cnts("br_lu_run");

    // Reset asserted in the stall cycle.
    set_lw(8); id_rs = 8;
    tick();
    exp_stall++;
    rst = 1;
    ex_br_taken = 1;
    #1;
    chk_ctl("rst_mid_stall", Rst);
    tick();
    rst = 0;
    idle();
    exp_stall = 0;
    exp_flush = 0;
    #1;
    chk_cnts("rst_mid_stall");
    set_lw(8); id_rs = 8;
    #1;
    chk_ctl("rst_stall_run", Stall);
    idle();

    // Reset asserted in the flush cycle; afterwards a branch must flush at once.
    ex_br_taken = 1;
    tick();
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk_cnts("rst_mid_flush");
    chk_ctl("rst_flush_run", Flush);
    idle();
    tick();

    // Saturation: 300 flushes on the low-ceiling copy.
    for (int k = 0; k < 300; k++) begin
      ex_br_taken = 1;
      tick();
      ex_br_taken = 0;
      tick();
    end
    exp_flush = 300;
    chk("sat_flush", s_flush_cnt, 16'h00FF);
    chk("sat_stall", s_stall_cnt, 16'd0);
    chk_cnts("sat_main");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
